iter_alu: RTL
=============

# iter_alu

Parametrised, multi-cycle ALU that replaces the combinational OP decoder and its single-cycle datapath with a registered, handshaked execution unit. It accepts one operation per START and executes ADD/SUB/AND/OR/PASS_A in one cycle. Shifts run iteratively, one bit position per cycle, and the shift distance is set by B. It sits between the lab's operand registers and the writeback path. Completion is reported with a DONE pulse, and status flags are registered alongside the result.

## Interface
- WIDTH, 16: datapath width. Must be a power of two, ≥ 4.
- SHW, $clog2(WIDTH): derived, not overridden. Width of the shift-amount field.

- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  request. Accepted only while BUSY=0.
- OP  in  3  operation code: ADD=000, SUB=001, SRA=010, SRL=011, SLL=100, AND=101, OR=110, PASS_A=111.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B. For shifts, the amount is B[SHW-1:0] and the upper bits are ignored.
- BUSY  out  1  high while an operation is in progress or completing.
- DONE  out  1  one-cycle pulse when RESULT and the flags update.
- RESULT  out  WIDTH  registered result. Held until the next completion.
- ZERO  out  1  RESULT == 0.
- CARRY  out  1  carry / last bit shifted out.
- OVF  out  1  signed overflow.

## Operation
- States: IDLE, SHIFT, FIN. BUSY = (state != IDLE). DONE = (state == FIN).
- IDLE with START=1: OP, A, B and the shift amount are captured.
  - ADD/SUB/AND/OR/PASS_A: the result is computed from the captured operands; next state is FIN.
  - Shift with amount 0: working register ← A, shifted-out bit ← 0, next state FIN.
  - Shift with amount > 0: working register ← A, counter ← amount, next state SHIFT.
- SHIFT: each cycle shifts the working register by one position and records the bit shifted out.
  - The counter decrements each cycle. When the counter is 1 on entry to the cycle, next state is FIN.
- FIN: RESULT, ZERO, CARRY and OVF are registered on entry. DONE=1 for exactly one cycle, then next state is IDLE.
- START while BUSY=1 is ignored and not queued. Changes on OP/A/B while BUSY have no effect.
- Arithmetic:
  - ADD = A+B. SUB = A+~B+1. Both use a WIDTH+1-bit sum.
  - CARRY = bit WIDTH of that sum. For SUB, CARRY=1 means no borrow.
  - OVF = operand signs equal (B inverted for SUB) and result sign differs.
- Shifts:
  - SRA fills with A[WIDTH-1]. SRL and SLL fill with 0.
  - CARRY = last bit shifted out; 0 when amount is 0. OVF = 0.
- AND, OR, PASS_A (RESULT=A): CARRY=0, OVF=0.
- ZERO is valid for every OP.

## Timing
- Reset values: state IDLE; BUSY=0, DONE=0, RESULT=0, ZERO=0, CARRY=0, OVF=0. These apply immediately on RST assertion, independent of CLK.
- Latency from the START-accept edge n: non-shift ops and zero-amount shifts assert DONE in cycle n+1. Shifts with amount k ≥ 1 assert DONE in cycle n+1+k.
- BUSY rises in the cycle after acceptance and falls in the cycle after DONE.
- Minimum spacing between accepted STARTs is 2 cycles for single-cycle ops. START may be asserted in the cycle after DONE.
- RST mid-operation aborts it: no DONE pulse, and RESULT and the flags return to 0.
- START asserted in the same cycle RST deasserts is not required to be accepted. START is accepted from the first edge with RST low.
- Maximum latency: WIDTH cycles (amount WIDTH-1).

## Test plan
- ADD A=0x7FFF B=0x0001 → DONE at n+1, RESULT=0x8000, OVF=1, CARRY=0, ZERO=0. Also ADD 0xFFFF+0x0001 → RESULT=0x0000, CARRY=1, ZERO=1, OVF=0.
- SUB A=0x0005 B=0x0005 → RESULT=0x0000, ZERO=1, CARRY=1, OVF=0. SUB A=0x8000 B=0x0001 → RESULT=0x7FFF, OVF=1.
- SRA A=0x8000 B=0x0004 → BUSY high 5 cycles, DONE at n+5, RESULT=0xF800, CARRY=0. SRL A=0x0003 B=0x0001 → RESULT=0x0001, CARRY=1.
- SLL A=0x0001 B=0xFFEF (amount 15) → DONE at n+16, RESULT=0x8000. Then SRL A=0x8001 B=0x0000 → DONE at n+1, RESULT=0x8001, CARRY=0.
- AND 0xF0F0,0x3C3C → 0x3030. While that operation is BUSY, pulse START with OR 0xF0F0,0x3C3C: the pulse is ignored and a single DONE is produced. A fresh OR started after IDLE → 0xFCFC. PASS_A A=0x1234 → 0x1234, CARRY=0, OVF=0.
- Start SRL A=0xFFFF B=0x000A, then assert RST 3 cycles later → all outputs 0 immediately and no DONE pulse. After RST release, ADD 0x0002+0x0003 → RESULT=0x0005 at n+1.

Source files
------------

// File: rtl/iter_alu.sv
// Multi-cycle ALU: single-cycle ADD/SUB/AND/OR/PASS_A, shifts iterate one bit per cycle.
// Result and flags are registered on entry to FIN, flagged by a one-cycle DONE pulse.
module iter_alu #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             ovf
);

  localparam int unsigned SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_SRA  = 3'b010,
    OP_SRL  = 3'b011,
    OP_SLL  = 3'b100,
    OP_AND  = 3'b101,
    OP_OR   = 3'b110,
    OP_PASS = 3'b111
  } op_t;

  state_t           state;
  op_t              op_r;
  logic [WIDTH-1:0] work;
  logic [SHW-1:0]   cnt;

  op_t              op_c;
  logic             sub_c;
  logic             is_shift_c;
  logic [SHW-1:0]   amt_c;
  logic [WIDTH-1:0] b_eff_c;
  logic [WIDTH:0]   sum_c;
  logic [WIDTH-1:0] res_c;
  logic             carry_c;
  logic             ovf_c;
  logic [WIDTH-1:0] step_c;
  logic             out_bit_c;

  // Single-cycle datapath, evaluated on the live operands at the accept edge
  always_comb begin
    op_c       = op_t'(op);
    sub_c      = (op_c == OP_SUB);
    is_shift_c = (op_c == OP_SRA) || (op_c == OP_SRL) || (op_c == OP_SLL);
    amt_c      = b[SHW-1:0];
    b_eff_c    = sub_c ? ~b : b;
    sum_c      = {1'b0, a} + {1'b0, b_eff_c} + {{WIDTH{1'b0}}, sub_c};
    res_c      = a;
    carry_c    = 1'b0;
    ovf_c      = 1'b0;
    case (op_c)
      OP_ADD, OP_SUB: begin
        res_c   = sum_c[WIDTH-1:0];
        carry_c = sum_c[WIDTH];
        ovf_c   = (a[WIDTH-1] == b_eff_c[WIDTH-1]) && (sum_c[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  res_c = a & b;
      OP_OR:   res_c = a | b;
      default: res_c = a;
    endcase
  end

  // One-position shift of the working register, direction from the captured op
  always_comb begin
    step_c    = {1'b0, work[WIDTH-1:1]};
    out_bit_c = work[0];
    case (op_r)
      OP_SRA:  step_c = {work[WIDTH-1], work[WIDTH-1:1]};
      OP_SLL: begin
        step_c    = {work[WIDTH-2:0], 1'b0};
        out_bit_c = work[WIDTH-1];
      end
      default: step_c = {1'b0, work[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      op_r   <= OP_ADD;
      work   <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      zero   <= 1'b0;
      carry  <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_r <= op_c;
            busy <= 1'b1;
            if (is_shift_c && (amt_c != '0)) begin
              work  <= a;
              cnt   <= amt_c;
              state <= SHIFT;
            end else begin
              // Non-shift ops and zero-amount shifts complete immediately
              result <= res_c;
              zero   <= (res_c == '0);
              carry  <= carry_c;
              ovf    <= ovf_c;
              done   <= 1'b1;
              state  <= FIN;
            end
          end
        end
        SHIFT: begin
          work <= step_c;
          cnt  <= cnt - SHW'(1);
          if (cnt == SHW'(1)) begin
            result <= step_c;
            zero   <= (step_c == '0);
            carry  <= out_bit_c;
            ovf    <= 1'b0;
            done   <= 1'b1;
            state  <= FIN;
          end
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
